decoder_rr_arbiter: RTL and testbench

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

---
 rtl/decoder_rr_arbiter.sv | 115 +++++++++++
 tb/tb_decoder_rr_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time and a mandatory
// one-cycle dead gap between grants. Grant is kept as an encoded index plus valid.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic [3:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       expiry;
  logic       early;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    timeout_d = 1'b0;
    found     = 1'b0;
    pick      = ptr_q;
    cand      = '0;
    expiry    = (cnt_q == HoldLast);
    early     = rel || !req[gnt_idx_q] || !en;

    // Search starts just after the last owner, which itself comes last.
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    unique case (state_q)
      StIdle, StGap: begin
        if (en && found) begin
          state_d   = StGrant;
          gnt_idx_d = pick;
          gnt_vld_d = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d   = StIdle;
          gnt_vld_d = 1'b0;
        end
      end
      StGrant: begin
        if (early || expiry) begin
          state_d   = StGap;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q;
          // Timeout only flags a revocation the owner did not cause itself.
          timeout_d = expiry && !early;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        gnt_vld_d = 1'b0;
      end
    endcase

    gnt_d = gnt_vld_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= 2'd3;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed-vector bench for decoder_rr_arbiter with MAX_HOLD=4: a table of
// per-cycle stimulus/expectation records plus short hand-written sequences.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic       busy;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Grant must always be the gated decode of the index.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [3:0] dec;
      dec = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
      n_tests++;
      if (gnt !== dec) begin
        n_fail++;
        $display("FAIL onehot t=%0t gnt=%b required=%b", $time, gnt, dec);
      end
    end
  end

  function automatic void add(input logic r, input logic e, input logic [3:0] rq,
                              input logic rl, input logic [3:0] g, input logic [1:0] i,
                              input logic v, input logic t, input logic b);
    vec_t x;
    x.rst = r; x.en = e; x.req = rq; x.rel = rl;
    x.gnt = g; x.idx = i; x.vld = v; x.to = t; x.busy = b;
    vecs.push_back(x);
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic rl,
                      input logic [3:0] g, input logic [1:0] i, input logic v,
                      input logic t, input logic b, input string name);
    logic [8:0] act, exp;
    rst = r; en = e; req = rq; rel = rl;
    @(posedge clk);
    #1;
    act = {gnt, gnt_idx, gnt_vld, timeout, busy};
    exp = {g, i, v, t, b};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t {gnt,idx,vld,to,busy} got=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
               name, $time, gnt, gnt_idx, gnt_vld, timeout, busy, g, i, v, t, b);
    end
  endtask

  initial begin
    // Basic grant, voluntary release, gap, rotation.
    add(1, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);
    add(0, 1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, 1);
    add(0, 1, 4'b1010, 1, 4'b0000, 2'd1, 0, 0, 1);
    add(0, 1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, 1);
    add(0, 1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, 1);
    // Owner drops its request: release without timeout.
    add(0, 1, 4'b0010, 0, 4'b0000, 2'd3, 0, 0, 1);
    add(0, 1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, 1);
    add(0, 1, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, 1);
    // Disabled: no grant, idle after the gap, index retained.
    add(0, 0, 4'b1111, 0, 4'b0000, 2'd1, 0, 0, 0);
    add(0, 0, 4'b1111, 0, 4'b0000, 2'd1, 0, 0, 0);
    add(1, 0, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, 0);
    // Full contention: four cycles each, gap with timeout, round-robin order.
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++)
        add(0, 1, 4'b1111, 0, 4'b0001 << o, 2'(o), 1, 0, 1);
      add(0, 1, 4'b1111, 0, 4'b0000, 2'(o), 0, 1, 1);
    end
    add(0, 1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, 1);

    @(negedge clk);
    chk_on = 1'b1;
    foreach (vecs[k]) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      step(vecs[k].rst, vecs[k].en, vecs[k].req, vecs[k].rel, vecs[k].gnt, vecs[k].idx,
           vecs[k].vld, vecs[k].to, vecs[k].busy, nm);
    end

    // Release coincident with expiry: no timeout, next owner is 3.
    step(1, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "exp_rst");
    step(0, 1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, 1, "exp_c0");
    step(0, 1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, 1, "exp_c1");
    step(0, 1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, 1, "exp_c2");
    step(0, 1, 4'b1100, 0, 4'b0100, 2'd2, 1, 0, 1, "exp_c3");
    step(0, 1, 4'b1100, 1, 4'b0000, 2'd2, 0, 0, 1, "exp_rel");
    step(0, 1, 4'b1100, 0, 4'b1000, 2'd3, 1, 0, 1, "exp_next");

    // Expiry with en dropped in the same cycle: timeout suppressed.
    step(0, 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 1, "en_c1");
    step(0, 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 1, "en_c2");
    step(0, 1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, 1, "en_c3");
    step(0, 0, 4'b1000, 0, 4'b0000, 2'd3, 0, 0, 1, "en_exp");
    step(0, 0, 4'b1000, 0, 4'b0000, 2'd3, 0, 0, 0, "en_idle");

    // Reset during a grant: everything clears, first grant goes to 0.
    step(1, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "mr_rst0");
    step(0, 1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, 1, "mr_own2");
    step(1, 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, 0, "mr_rst1");
    step(0, 1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, 1, "mr_first");

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
